// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// oversampling tap offsets, frame constants and small helpers.
package uart_rx_pkg;

  // Default widths of the oversampling ratio / edge count and the data field
  localparam int PRESCALE_W_DEF = 5;
  localparam int DATA_BITS      = 8;

  // One-hot FSM state encoding
  localparam logic [4:0] ST_IDLE   = 5'b00001;
  localparam logic [4:0] ST_START  = 5'b00010;
  localparam logic [4:0] ST_DATA   = 5'b00100;
  localparam logic [4:0] ST_PARITY = 5'b01000;
  localparam logic [4:0] ST_STOP   = 5'b10000;

  // Three sampling taps around the middle of each bit: P/2-1, P/2, P/2+1
  localparam int NUM_TAPS      = 3;
  localparam int TAP_OFS_EARLY = -1;
  localparam int TAP_OFS_MID   = 0;
  localparam int TAP_OFS_LATE  = 1;

  // Registered end-of-frame strobes
  typedef struct packed {
    logic data_valid;
    logic par_err;
    logic stp_err;
  } rx_strobe_t;

  // Offset from P/2 of tap number 'tap'
  function automatic int tap_offset(input int tap);
    case (tap)
      0:       return TAP_OFS_EARLY;
      1:       return TAP_OFS_MID;
      default: return TAP_OFS_LATE;
    endcase
  endfunction

  // 2-out-of-3 majority vote
  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Oversampler: captures the serial line at three edges around the middle of
// each bit and presents the majority of those captures as the bit value.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int Prescale_W = PRESCALE_W_DEF
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  RX_IN,
  input  logic [Prescale_W-1:0] Prescale,
  input  logic [Prescale_W-1:0] edge_count,
  output logic                  sampled_bit
);

  logic [Prescale_W-1:0] half_point;
  logic [NUM_TAPS-1:0]   tap_bits;

  assign half_point = Prescale >> 1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
      logic [Prescale_W-1:0] tap_edge;
      logic                  tap_reg;

      assign tap_edge = half_point + Prescale_W'(tap_offset(gi));

      // Capture the line once per bit, on this tap's edge position
      always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
          tap_reg <= 1'b0;
        end else if (edge_count == tap_edge) begin
          tap_reg <= RX_IN;
        end
      end

      assign tap_bits[gi] = tap_reg;
    end
  endgenerate

  // Valid from edge P/2+2 onward, i.e. well before the bit's edge_end
  assign sampled_bit = majority3(tap_bits);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: detects the start bit, drives the shared edge/bit
// counter, deserializes the data bits LSB-first, checks optional parity and
// the stop bit, and emits the received byte with one-cycle strobes.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int Prescale_W = PRESCALE_W_DEF,
  parameter int Data_W     = DATA_BITS
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  RX_IN,
  input  logic [Prescale_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [3:0]            bit_count,
  input  logic [Prescale_W-1:0] edge_count,
  input  logic                  edge_end,
  output logic                  cnt_en,
  output logic [Data_W-1:0]     P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  // bit_count of the last data bit (the start bit is index 0)
  localparam logic [3:0] LAST_DATA_IDX = 4'(Data_W);

  logic [4:0]        state_reg;
  logic [4:0]        state_next;
  logic              sampled_bit;
  logic [Data_W-1:0] shift_reg;
  logic [Data_W-1:0] p_data_reg;
  logic              par_en_reg;
  logic              par_typ_reg;
  logic              perr_reg;
  rx_strobe_t        strobe_reg;

  uart_rx_sampler #(
    .Prescale_W (Prescale_W)
  ) u_sampler (
    .CLK         (CLK),
    .Reset       (Reset),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .edge_count  (edge_count),
    .sampled_bit (sampled_bit)
  );

  // Next-state logic: every move out of a counted state waits for edge_end
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (!RX_IN) state_next = ST_START;
      end
      ST_START: begin
        // A start bit that votes high was a glitch on the line
        if (edge_end) state_next = sampled_bit ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        // '>=' keeps the FSM from wandering if the counter ever overshoots
        if (edge_end && (bit_count >= LAST_DATA_IDX)) begin
          state_next = par_en_reg ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (edge_end) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (edge_end) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Frame datapath: parity shadow, shift register, parity check, output byte
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      par_en_reg  <= 1'b0;
      par_typ_reg <= 1'b0;
      perr_reg    <= 1'b0;
      shift_reg   <= '0;
      p_data_reg  <= '0;
      strobe_reg  <= '0;
    end else begin
      strobe_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          // Parity settings are frozen for the duration of a frame
          par_en_reg  <= PAR_EN;
          par_typ_reg <= PAR_TYP;
          if (!RX_IN) perr_reg <= 1'b0;
        end
        ST_DATA: begin
          if (edge_end) shift_reg <= {sampled_bit, shift_reg[Data_W-1:1]};
        end
        ST_PARITY: begin
          if (edge_end) perr_reg <= ((^shift_reg) ^ sampled_bit) != par_typ_reg;
        end
        ST_STOP: begin
          if (edge_end) begin
            if (sampled_bit && !perr_reg) begin
              p_data_reg            <= shift_reg;
              strobe_reg.data_valid <= 1'b1;
            end
            strobe_reg.par_err <= perr_reg;
            strobe_reg.stp_err <= ~sampled_bit;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs and registered strobes
  assign cnt_en     = (state_reg != ST_IDLE);
  assign busy       = (state_reg != ST_IDLE);
  assign P_DATA     = p_data_reg;
  assign data_valid = strobe_reg.data_valid;
  assign par_err    = strobe_reg.par_err;
  assign stp_err    = strobe_reg.stp_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed testbench for uart_rx_ctrl with a behavioural edge/bit counter.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       RX_IN;
  logic [4:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [3:0] bit_count;
  logic [4:0] edge_count;
  logic       edge_end;
  logic       cnt_en;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int         dv_cyc_q[$];
  logic [7:0] dv_byte_q[$];
  int         pe_cnt      = 0;
  int         se_cnt      = 0;
  int         pe_cyc      = -1;
  int         se_cyc      = -1;
  int         overlap_cnt = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  uart_rx_ctrl #(
    .Prescale_W (5),
    .Data_W     (8)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .bit_count  (bit_count),
    .edge_count (edge_count),
    .edge_end   (edge_end),
    .cnt_en     (cnt_en),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .busy       (busy)
  );

  // Shared counter: held at 1/0 while disabled, wraps at Prescale
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      edge_count <= 5'd1;
      bit_count  <= 4'd0;
    end else if (!cnt_en) begin
      edge_count <= 5'd1;
      bit_count  <= 4'd0;
    end else if (edge_count == Prescale) begin
      edge_count <= 5'd1;
      bit_count  <= bit_count + 4'd1;
    end else begin
      edge_count <= edge_count + 5'd1;
    end
  end

  assign edge_end = (edge_count == Prescale);

  // Strobe monitor, one line per received event
  always @(negedge CLK) begin
    if (data_valid) begin
      dv_cyc_q.push_back(cyc);
      dv_byte_q.push_back(P_DATA);
      $display("[cyc %0d] rx data_valid byte=0x%02h", cyc, P_DATA);
    end
    if (par_err) begin
      pe_cnt = pe_cnt + 1;
      pe_cyc = cyc;
      $display("[cyc %0d] rx par_err", cyc);
    end
    if (stp_err) begin
      se_cnt = se_cnt + 1;
      se_cyc = cyc;
      $display("[cyc %0d] rx stp_err", cyc);
    end
    if (data_valid && (par_err || stp_err)) overlap_cnt = overlap_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input int p);
    RX_IN = b;
    step(p);
  endtask

  // Drives start, 8 data bits LSB-first, optional parity, stop; line left high
  task automatic send_frame(input logic [7:0] data, input logic with_par,
                            input logic par_bit, input logic stop_bit, input int p);
    $display("[cyc %0d] tx frame data=0x%02h par_en=%0d par_bit=%0d stop=%0d P=%0d",
             cyc, data, with_par, par_bit, stop_bit, p);
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(data[i], p);
    if (with_par) drive_bit(par_bit, p);
    drive_bit(stop_bit, p);
    RX_IN = 1'b1;
  endtask

  function automatic int dv_cyc_at(input int idx);
    return (idx < dv_cyc_q.size()) ? dv_cyc_q[idx] : -1;
  endfunction

  function automatic logic [7:0] dv_byte_at(input int idx);
    return (idx < dv_byte_q.size()) ? dv_byte_q[idx] : 8'hxx;
  endfunction

  initial begin
    int s;
    int dv_base;
    int pe_base;
    int se_base;

    Reset    = 1'b0;
    RX_IN    = 1'b1;
    Prescale = 5'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    step(3);
    check("reset_ctrl", 32'({cnt_en, busy, data_valid, par_err, stp_err}), 32'h0);
    check("reset_pdata", 32'(P_DATA), 32'h00);
    Reset = 1'b1;
    step(3);
    check("idle_busy", 32'(busy), 32'h0);

    // P=8, no parity, 0xA5: strobe 10*8+1 cycles after the start edge
    s = cyc; dv_base = dv_cyc_q.size(); pe_base = pe_cnt; se_base = se_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8);
    step(4);
    check("a5_dv_count", 32'(dv_cyc_q.size() - dv_base), 32'd1);
    check("a5_latency", 32'(dv_cyc_at(dv_base) - s), 32'd81);
    check("a5_byte", 32'(dv_byte_at(dv_base)), 32'hA5);
    check("a5_pdata", 32'(P_DATA), 32'hA5);
    check("a5_busy_after", 32'(busy), 32'h0);
    check("a5_no_err", 32'((pe_cnt - pe_base) + (se_cnt - se_base)), 32'd0);

    // P=16, even parity, 0x3C with correct parity bit 0
    Prescale = 5'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    step(2);
    s = cyc; dv_base = dv_cyc_q.size(); pe_base = pe_cnt;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16);
    step(4);
    check("3c_dv_count", 32'(dv_cyc_q.size() - dv_base), 32'd1);
    check("3c_latency", 32'(dv_cyc_at(dv_base) - s), 32'd177);
    check("3c_byte", 32'(dv_byte_at(dv_base)), 32'h3C);
    check("3c_no_perr", 32'(pe_cnt - pe_base), 32'd0);

    // Same frame, wrong parity bit
    s = cyc; dv_base = dv_cyc_q.size(); pe_base = pe_cnt; se_base = se_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16);
    step(4);
    check("3c_bad_perr_count", 32'(pe_cnt - pe_base), 32'd1);
    check("3c_bad_perr_cycle", 32'(pe_cyc - s), 32'd177);
    check("3c_bad_no_dv", 32'(dv_cyc_q.size() - dv_base), 32'd0);
    check("3c_bad_no_stperr", 32'(se_cnt - se_base), 32'd0);
    check("3c_bad_pdata_held", 32'(P_DATA), 32'h3C);

    // P=8, three-cycle low glitch: START rejects it at its edge_end (cycle 8)
    Prescale = 5'd8; PAR_EN = 1'b0;
    step(2);
    s = cyc; dv_base = dv_cyc_q.size(); pe_base = pe_cnt; se_base = se_cnt;
    RX_IN = 1'b0;
    step(3);
    RX_IN = 1'b1;
    step(5);
    check("glitch_cnt_en_c8", 32'(cnt_en), 32'h1);
    step(1);
    check("glitch_cnt_en_c9", 32'(cnt_en), 32'h0);
    check("glitch_busy_c9", 32'(busy), 32'h0);
    step(4);
    check("glitch_no_strobes",
          32'((dv_cyc_q.size() - dv_base) + (pe_cnt - pe_base) + (se_cnt - se_base)), 32'd0);

    // P=8, odd parity, 0x81 (two ones -> parity bit 1), stop bit low
    PAR_EN = 1'b1; PAR_TYP = 1'b1;
    step(2);
    s = cyc; dv_base = dv_cyc_q.size(); pe_base = pe_cnt; se_base = se_cnt;
    send_frame(8'h81, 1'b1, 1'b1, 1'b0, 8);
    step(4);
    check("stop0_stperr_count", 32'(se_cnt - se_base), 32'd1);
    check("stop0_stperr_cycle", 32'(se_cyc - s), 32'd89);
    check("stop0_no_perr", 32'(pe_cnt - pe_base), 32'd0);
    check("stop0_no_dv", 32'(dv_cyc_q.size() - dv_base), 32'd0);
    check("stop0_pdata_held", 32'(P_DATA), 32'h3C);

    // Same with a wrong parity bit: both errors in the same cycle
    s = cyc; dv_base = dv_cyc_q.size(); pe_base = pe_cnt; se_base = se_cnt;
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 8);
    step(4);
    check("both_perr_count", 32'(pe_cnt - pe_base), 32'd1);
    check("both_stperr_count", 32'(se_cnt - se_base), 32'd1);
    check("both_perr_cycle", 32'(pe_cyc - s), 32'd89);
    check("both_stperr_cycle", 32'(se_cyc - s), 32'd89);
    check("both_no_dv", 32'(dv_cyc_q.size() - dv_base), 32'd0);
    check("dv_never_with_err", 32'(overlap_cnt), 32'd0);

    // Back-to-back 0x00 then 0xFF with no idle gap on the line. The second
    // start bit is first seen in the IDLE cycle following the stop edge_end,
    // i.e. cycle 81, so its strobe lands another 81 cycles later.
    PAR_EN = 1'b0;
    step(2);
    s = cyc; dv_base = dv_cyc_q.size();
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 8);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 8);
    step(4);
    check("b2b_dv_count", 32'(dv_cyc_q.size() - dv_base), 32'd2);
    check("b2b_first_cycle", 32'(dv_cyc_at(dv_base) - s), 32'd81);
    check("b2b_first_byte", 32'(dv_byte_at(dv_base)), 32'h00);
    check("b2b_second_cycle", 32'(dv_cyc_at(dv_base + 1) - s), 32'd162);
    check("b2b_second_byte", 32'(dv_byte_at(dv_base + 1)), 32'hFF);

    // Reset in the middle of data bit 4 of a partial frame
    dv_base = dv_cyc_q.size(); pe_base = pe_cnt; se_base = se_cnt;
    $display("[cyc %0d] tx partial frame, reset at data bit 4", cyc);
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 8);
    step(4);
    check("mid_frame_busy", 32'(busy), 32'h1);
    Reset = 1'b0;
    RX_IN = 1'b1;
    #1;
    check("rst_ctrl", 32'({cnt_en, busy, data_valid, par_err, stp_err}), 32'h0);
    check("rst_pdata", 32'(P_DATA), 32'h00);
    step(2);
    Reset = 1'b1;
    step(3);
    check("rst_no_strobes",
          32'((dv_cyc_q.size() - dv_base) + (pe_cnt - pe_base) + (se_cnt - se_base)), 32'd0);

    s = cyc; dv_base = dv_cyc_q.size();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 8);
    step(4);
    check("5a_dv_count", 32'(dv_cyc_q.size() - dv_base), 32'd1);
    check("5a_latency", 32'(dv_cyc_at(dv_base) - s), 32'd81);
    check("5a_byte", 32'(dv_byte_at(dv_base)), 32'h5A);
    check("5a_pdata", 32'(P_DATA), 32'h5A);
    check("5a_busy_after", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
